// File: rtl/picomips_io_ctrl_if.sv
// Core-side handshake bundle of the picoMIPS front-panel controller.
// master: the controller (drives index/start, receives result/done).
// slave:  the picoMIPS core.
interface picomips_io_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] core_idx;
  logic              core_start;
  logic [DATA_W-1:0] core_result;
  logic              core_done;

  modport master (
    output core_idx,
    output core_start,
    input  core_result,
    input  core_done
  );

  modport slave (
    input  core_idx,
    input  core_start,
    output core_result,
    output core_done
  );
endinterface

// File: rtl/picomips_io_ctrl.sv
// picoMIPS front-panel controller: debounces the start switch, launches the core
// on a rising edge, waits for done (optional timeout) and keeps a result history
// that can be shown on the LEDs.
module picomips_io_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 1024,
  localparam int unsigned SEL_W    = $clog2(RES_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   sw_data,
  input  logic                sw_go,
  input  logic                hist_show,
  input  logic [SEL_W-1:0]    hist_sel,
  picomips_io_ctrl_if.master  core,
  output logic [DATA_W-1:0]   LED,
  output logic                busy,
  output logic                err,
  output logic                missed
);

  localparam int unsigned DbW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int unsigned CntW  = SEL_W + 1;
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitLast = (TIMEOUT == 0) ? '0 : WaitW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(RES_DEPTH);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  logic              go_s1_q, go_s2_q;
  logic [DATA_W-1:0] data_s1_q, data_s2_q;
  logic              go_db_q, go_db_prev_q;
  logic [DbW-1:0]    db_cnt_q;
  logic              go_rise;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q;
  logic              done_hit, timeout_hit, launch;
  logic [DATA_W-1:0] idx_q;
  logic              err_q, missed_q;

  logic [DATA_W-1:0] hist_q [RES_DEPTH];
  logic [SEL_W-1:0]  wr_ptr_q, rd_idx;
  logic [CntW-1:0]   count_q;
  logic [DATA_W-1:0] latest_q, led_q, hist_rd;

  // Two-flop synchroniser and debouncer; debounced go resets high so a switch
  // held through reset must be released before it can launch a run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_s1_q      <= 1'b0;
      go_s2_q      <= 1'b0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      go_db_q      <= 1'b1;
      go_db_prev_q <= 1'b1;
      db_cnt_q     <= '0;
    end else begin
      go_s1_q      <= sw_go;
      go_s2_q      <= go_s1_q;
      data_s1_q    <= sw_data;
      data_s2_q    <= data_s1_q;
      go_db_prev_q <= go_db_q;
      if (go_s2_q == go_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        go_db_q  <= go_s2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end
  end

  assign go_rise = go_db_q & ~go_db_prev_q;
  assign launch  = (state_q == StIdle) && go_rise;

  // Next-state logic; done takes priority over timeout on the same edge.
  always_comb begin
    state_d     = state_q;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle:   if (go_rise) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait: begin
        if (core.core_done) begin
          done_hit = 1'b1;
          state_d  = StIdle;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == WaitLast)) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // Run control: state, wait counter, latched index and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + WaitW'(1) : '0;
      if (launch) begin
        idx_q    <= data_s2_q;
        err_q    <= 1'b0;
        missed_q <= 1'b0;
      end else if (go_rise) begin
        missed_q <= 1'b1;
      end
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  // Entries older than the number of results captured read as zero.
  always_comb begin
    rd_idx  = wr_ptr_q - SEL_W'(1) - hist_sel;
    hist_rd = ({1'b0, hist_sel} >= count_q) ? '0 : hist_q[rd_idx];
  end

  // Result history, latest result and registered LED mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RES_DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      latest_q <= '0;
      led_q    <= '0;
    end else begin
      if (done_hit) begin
        hist_q[wr_ptr_q] <= core.core_result;
        wr_ptr_q         <= wr_ptr_q + SEL_W'(1);
        latest_q         <= core.core_result;
        if (count_q != CntFull) count_q <= count_q + CntW'(1);
      end
      led_q <= hist_show ? hist_rd : latest_q;
    end
  end

  assign core.core_idx   = idx_q;
  assign core.core_start = (state_q == StLaunch);
  assign busy            = (state_q != StIdle);
  assign err             = err_q;
  assign missed          = missed_q;
  assign LED             = led_q;

endmodule

// File: doc/picomips_io_ctrl.md
# picomips_io_ctrl

Parametrised front-panel controller between the board switches/LEDs and the picoMIPS core. It debounces the raw start switch and detects its rising edge. On that edge it latches the switch data as the core index, issues a one-cycle start, and waits for the core's done with an optional timeout. It keeps a circular history of the last RES_DEPTH results, which can be shown on the LEDs.

## Interface
- DATA_W, 8: width of switch data, core index, core result and LED bus
- DB_CYCLES, 16: consecutive stable cycles required before the debounced start switch changes (≥1)
- RES_DEPTH, 4: result history entries (power of 2, ≥2)
- TIMEOUT, 1024: max cycles waiting for core_done; 0 disables the timeout
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- sw_data  in  DATA_W  raw switch data (index for the next run)
- sw_go  in  1  raw start switch, asynchronous to clk
- hist_show  in  1  1: LED shows the history entry picked by hist_sel; 0: LED shows the latest result
- hist_sel  in  log2(RES_DEPTH)  history age (0 = newest)
- core_result  in  DATA_W  result from the core, valid while core_done=1
- core_done  in  1  core completion strobe
- core_idx  out  DATA_W  latched index for the core
- core_start  out  1  one-cycle start pulse
- LED  out  DATA_W  display bus
- busy  out  1  run in progress
- err  out  1  last run timed out (sticky until next launch)
- missed  out  1  go edge arrived while busy (sticky until next launch)

## Operation
- Reset: every output is 0. The history holds all zeros, the entry count is 0, the FSM is in IDLE, and the debounced go value is 1. Because debounced go resets to 1, a switch held high through reset never triggers a run; the switch must first go low.
- Sync: sw_go passes through two flops, then the debouncer.
- Debounce: a counter runs while the synced value differs from the debounced value and clears when they match. When the count reaches DB_CYCLES, the debounced value flips and the counter clears.
- Edge: go_rise is a one-cycle pulse when the debounced value goes 0→1.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH on go_rise. On this transition core_idx ← sw_data (the synced copy taken with go), and err and missed clear.
  - LAUNCH: core_start=1 for exactly this cycle, then → WAIT.
  - WAIT → IDLE on core_done=1. At that edge the result is written to history, the count increments (saturating at RES_DEPTH), and the latest-result register is loaded.
  - WAIT → IDLE on timeout: the wait counter hits TIMEOUT with no done. err←1, nothing is written, and LED is unchanged.
  - core_done and timeout on the same edge: done wins.
- busy=1 in LAUNCH and WAIT.
- core_done outside WAIT is ignored, including during LAUNCH.
- go_rise in LAUNCH or WAIT: no new run starts, no run is queued, and missed←1.
- History: a circular buffer with a write pointer that wraps mod RES_DEPTH. The entry shown for hist_sel is the one at write pointer − 1 − hist_sel (mod RES_DEPTH). If hist_sel ≥ count, that entry reads 0.
- LED is registered: it shows the history entry when hist_show=1, otherwise the latest result.
- Reset asserted mid-run immediately returns all state to reset values. A core_done pending at that moment is lost.

## Timing
- The raw sw_go transition must be stable for DB_CYCLES cycles. The debounced value changes 2+DB_CYCLES edges after the first edge that samples the new raw value.
- From go_rise, the FSM enters LAUNCH one edge later. core_start and the new core_idx appear in that cycle. core_idx holds until the next launch.
- core_done is sampled from the first WAIT cycle. After the capturing edge, LED shows the new result one edge later.
- A change on hist_show or hist_sel reaches LED one edge later.
- Timeout: err rises on the edge where the WAIT counter reaches TIMEOUT, which is TIMEOUT cycles after entering WAIT.
- Minimum go period: two debounce intervals. Faster toggling is filtered.

## Test plan
- Hold sw_go=1 and sw_data=0xFF through reset, then release reset: no core_start, LED=0x00, busy=0.
- With DB_CYCLES=16: sw_go 0→1, sw_data=0x14, core answers done with 0x5A after 10 cycles. Expect core_start once, core_idx=0x14, and LED=0x5A one edge after done.
- Glitch sw_go high for 5 cycles with DB_CYCLES=16: no go_rise and no core_start.
- Pulse go again during WAIT: missed=1, only one core_start is issued, and missed clears on the next launch.
- With TIMEOUT=32, never assert done: err=1 after 32 WAIT cycles, FSM back in IDLE, busy=0, LED unchanged.
- Run 6 times (results 1..6) with RES_DEPTH=4, then set hist_show=1 and step hist_sel 0..3: LED shows 6, 5, 4, 3. After a reset with a single run of result 9, hist_sel=1 reads 0.
